// File: rtl/gshare_pkg.sv
// Shared types and helpers for the gshare branch predictor.
package gshare_pkg;

  // Predictor lifecycle: table sweep after reset, then normal operation.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Saturating up/down step for a counter of 'width' bits (1..32).
  // Values are carried in 32 bits; callers truncate to their own width.
  function automatic logic [31:0] sat_step(input logic [31:0] val,
                                           input logic        up,
                                           input int unsigned width);
    logic [31:0] max_v;
    logic [31:0] res;
    max_v = 32'hFFFF_FFFF >> (32 - width);
    res   = val;
    if (up) begin
      if (val < max_v) res = val + 32'd1;
    end else begin
      if (val != 32'd0) res = val - 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/gshare_predictor_v2_if.sv
// Fetch-side / resolution-side bundle for the gshare predictor.
//
// Handshake: there is no ready signal. While the predictor is in RUN every
// cycle with predict_valid or train_valid high is consumed on the next
// rising edge; while init_busy is high both valids are ignored entirely.
// predict_taken/predict_history are combinational from predict_pc and the
// current global history, valid in the same cycle as the request.
interface gshare_predictor_v2_if #(
  parameter int PC_W   = 7,
  parameter int HIST_W = 7,
  parameter int STAT_W = 16
) ();

  logic                  predict_valid;
  logic [PC_W-1:0]       predict_pc;
  logic                  predict_taken;
  logic [HIST_W-1:0]     predict_history;

  logic                  train_valid;
  logic [PC_W-1:0]       train_pc;
  logic                  train_taken;
  logic                  train_mispredicted;
  logic [HIST_W-1:0]     train_history;

  logic                  init_busy;
  logic [STAT_W-1:0]     stat_predicts;
  logic [STAT_W-1:0]     stat_mispredicts;

  // Debug view of the FSM state.
  gshare_pkg::state_t    state;

  // Requester side (fetch + branch resolution).
  modport master (
    output predict_valid, predict_pc,
    output train_valid, train_pc, train_taken, train_mispredicted, train_history,
    input  predict_taken, predict_history,
    input  init_busy, stat_predicts, stat_mispredicts, state
  );

  // Predictor side.
  modport slave (
    input  predict_valid, predict_pc,
    input  train_valid, train_pc, train_taken, train_mispredicted, train_history,
    output predict_taken, predict_history,
    output init_busy, stat_predicts, stat_mispredicts, state
  );

endinterface

// File: rtl/gshare_pht.sv
// Pattern history table: 2^HIST_W saturating counters, one asynchronous
// read port and one synchronous write port. The write port either loads a
// value (init sweep) or steps the addressed counter up/down with saturation
// (training), so the read-modify-write for training stays inside the table.
module gshare_pht
  import gshare_pkg::*;
#(
  parameter int HIST_W = 7,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic [HIST_W-1:0] rd_addr_i,
  output logic [CTR_W-1:0]  rd_data_o,
  input  logic              we_i,
  input  logic [HIST_W-1:0] wr_addr_i,
  input  logic              wr_load_i,
  input  logic [CTR_W-1:0]  wr_data_i,
  input  logic              wr_up_i
);

  localparam int DEPTH = 1 << HIST_W;

  logic [CTR_W-1:0] mem_q [DEPTH];
  logic [CTR_W-1:0] wr_val;

  // Read is combinational; a same-cycle write is seen only after the edge.
  assign rd_data_o = mem_q[rd_addr_i];

  // Value written: load for the sweep, saturating step for training.
  always_comb begin
    wr_val = wr_data_i;
    if (!wr_load_i) begin
      wr_val = CTR_W'(sat_step(32'(mem_q[wr_addr_i]), wr_up_i, CTR_W));
    end
  end

  // Single write port; contents need no reset because the sweep rewrites them.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_val;
    end
  end

endmodule

// File: rtl/gshare_predictor_v2.sv
// gshare branch direction predictor: PHT indexed by PC XOR global history,
// speculative history update on predict, history repair on mispredict,
// post-reset table sweep and saturating statistics. HIST_W must be >= 2
// and PC_W >= HIST_W.
module gshare_predictor_v2
  import gshare_pkg::*;
#(
  parameter int PC_W     = 7,
  parameter int HIST_W   = 7,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1,
  parameter int STAT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gshare_predictor_v2_if.slave bus
);

  state_t            state_q;
  logic              init_busy_q;
  logic [HIST_W-1:0] sweep_q;
  logic [HIST_W-1:0] ghr_q;
  logic [HIST_W-1:0] ghr_d;
  logic [STAT_W-1:0] stat_pred_q;
  logic [STAT_W-1:0] stat_pred_d;
  logic [STAT_W-1:0] stat_misp_q;
  logic [STAT_W-1:0] stat_misp_d;

  logic              run;
  logic              accept_pred;
  logic              accept_train;
  logic              repair;
  logic              pred_taken;
  logic [HIST_W-1:0] pred_idx;
  logic [HIST_W-1:0] train_idx;
  logic [CTR_W-1:0]  rd_ctr;

  logic              pht_we;
  logic [HIST_W-1:0] pht_waddr;
  logic              pht_load;

  assign run          = (state_q == ST_RUN);
  assign accept_pred  = run && bus.predict_valid;
  assign accept_train = run && bus.train_valid;
  assign repair       = accept_train && bus.train_mispredicted;

  assign pred_idx  = bus.predict_pc[HIST_W-1:0] ^ ghr_q;
  assign train_idx = bus.train_pc[HIST_W-1:0] ^ bus.train_history;

  // Prediction is forced to not-taken with zero history while sweeping.
  assign pred_taken = run && rd_ctr[CTR_W-1];

  // The sweep owns the write port in INIT; training owns it in RUN.
  assign pht_we    = !run || accept_train;
  assign pht_waddr = run ? train_idx : sweep_q;
  assign pht_load  = !run;

  gshare_pht #(
    .HIST_W (HIST_W),
    .CTR_W  (CTR_W)
  ) u_pht (
    .clk       (clk),
    .rd_addr_i (pred_idx),
    .rd_data_o (rd_ctr),
    .we_i      (pht_we),
    .wr_addr_i (pht_waddr),
    .wr_load_i (pht_load),
    .wr_data_i (CTR_W'(INIT_CTR)),
    .wr_up_i   (bus.train_taken)
  );

  // FSM: sweep one PHT entry per cycle from address 0, then run forever.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_busy_q <= 1'b1;
      sweep_q     <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (&sweep_q) begin
            state_q     <= ST_RUN;
            init_busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          state_q     <= ST_RUN;
          init_busy_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_INIT;
          init_busy_q <= 1'b1;
          sweep_q     <= '0;
        end
      endcase
    end
  end

  // Next GHR: a mispredict repair overrides the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (repair) begin
      ghr_d = {bus.train_history[HIST_W-2:0], bus.train_taken};
    end else if (accept_pred) begin
      ghr_d = {ghr_q[HIST_W-2:0], pred_taken};
    end
  end

  // Next statistics values: saturating increments on accepted events.
  always_comb begin
    stat_pred_d = stat_pred_q;
    stat_misp_d = stat_misp_q;
    if (accept_pred) begin
      stat_pred_d = STAT_W'(sat_step(32'(stat_pred_q), 1'b1, STAT_W));
    end
    if (repair) begin
      stat_misp_d = STAT_W'(sat_step(32'(stat_misp_q), 1'b1, STAT_W));
    end
  end

  // History and statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q       <= '0;
      stat_pred_q <= '0;
      stat_misp_q <= '0;
    end else begin
      ghr_q       <= ghr_d;
      stat_pred_q <= stat_pred_d;
      stat_misp_q <= stat_misp_d;
    end
  end

  assign bus.predict_taken    = pred_taken;
  assign bus.predict_history  = run ? ghr_q : '0;
  assign bus.init_busy        = init_busy_q;
  assign bus.stat_predicts    = stat_pred_q;
  assign bus.stat_mispredicts = stat_misp_q;
  assign bus.state            = state_q;

endmodule

// File: tb/tb_gshare_predictor_v2.sv
// Directed bench for gshare_predictor_v2 with a reference model and an
// expected-prediction queue. A second instance with 4-bit statistics shares
// the same stimulus to exercise statistic saturation.
module tb_gshare_predictor_v2;
  import gshare_pkg::*;

  localparam int PC_W   = 7;
  localparam int HIST_W = 7;
  localparam int DEPTH  = 128;
  localparam int CTR_MAX = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gshare_predictor_v2_if #(.PC_W(PC_W), .HIST_W(HIST_W), .STAT_W(16)) bus ();
  gshare_predictor_v2_if #(.PC_W(PC_W), .HIST_W(HIST_W), .STAT_W(4))  bus4 ();

  assign bus4.predict_valid      = bus.predict_valid;
  assign bus4.predict_pc         = bus.predict_pc;
  assign bus4.train_valid        = bus.train_valid;
  assign bus4.train_pc           = bus.train_pc;
  assign bus4.train_taken        = bus.train_taken;
  assign bus4.train_mispredicted = bus.train_mispredicted;
  assign bus4.train_history      = bus.train_history;

  gshare_predictor_v2 #(
    .PC_W(PC_W), .HIST_W(HIST_W), .CTR_W(2), .INIT_CTR(1), .STAT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  gshare_predictor_v2 #(
    .PC_W(PC_W), .HIST_W(HIST_W), .CTR_W(2), .INIT_CTR(1), .STAT_W(4)
  ) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  // ---------------- scoreboard / model ----------------
  logic [HIST_W:0] exp_q[$];
  int              m_pht [DEPTH];
  logic [6:0]      m_ghr;
  int              m_sp;
  int              m_smp;
  int              n_cmp = 0;
  int              n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
    m_ghr = '0;
    m_sp  = 0;
    m_smp = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.predict_valid      = 1'b0;
    bus.predict_pc         = '0;
    bus.train_valid        = 1'b0;
    bus.train_pc           = '0;
    bus.train_taken        = 1'b0;
    bus.train_mispredicted = 1'b0;
    bus.train_history      = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Counts edges until init_busy drops; checks outputs stay quiet meanwhile.
  task automatic wait_sweep(input string tag, input int exp_cycles, input bit pulse);
    int cnt;
    bit bad;
    cnt = 0;
    bad = 1'b0;
    while (cnt < 1000) begin
      if (pulse) begin
        bus.predict_valid      = 1'($urandom_range(0, 1));
        bus.predict_pc         = 7'($urandom_range(0, 127));
        bus.train_valid        = 1'($urandom_range(0, 1));
        bus.train_pc           = 7'($urandom_range(0, 127));
        bus.train_taken        = 1'($urandom_range(0, 1));
        bus.train_mispredicted = 1'b1;
        bus.train_history      = 7'($urandom_range(0, 127));
      end
      #2;
      if (bus.predict_taken !== 1'b0 || bus.predict_history !== 7'd0 ||
          bus.stat_predicts !== 16'd0 || bus.stat_mispredicts !== 16'd0 ||
          bus4.stat_predicts !== 4'd0 || bus4.init_busy !== 1'b1 ||
          bus.init_busy !== 1'b1)
        bad = 1'b1;
      @(posedge clk);
      #1;
      cnt++;
      if (bus.init_busy !== 1'b1) break;
    end
    drive_idle();
    check({tag, "_len"}, 32'(cnt), 32'(exp_cycles));
    check({tag, "_quiet"}, {31'd0, bad}, 32'd0);
  endtask

  // One RUN cycle: drive, compare prediction via the queue, advance model.
  task automatic do_cycle(input logic pv, input logic [6:0] ppc,
                          input logic tv, input logic [6:0] tpc,
                          input logic tt, input logic tm, input logic [6:0] th);
    logic [6:0]      pidx;
    logic [6:0]      tidx;
    logic            pt;
    logic [HIST_W:0] exp_v;
    bus.predict_valid      = pv;
    bus.predict_pc         = ppc;
    bus.train_valid        = tv;
    bus.train_pc           = tpc;
    bus.train_taken        = tt;
    bus.train_mispredicted = tm;
    bus.train_history      = th;
    pidx = ppc ^ m_ghr;
    pt   = (m_pht[pidx] >= 2);
    exp_q.push_back({pt, m_ghr});
    #2;
    exp_v = exp_q.pop_front();
    check("pred", {24'd0, bus.predict_taken, bus.predict_history}, {24'd0, exp_v});
    if (tv) begin
      tidx = tpc ^ th;
      if (tt) m_pht[tidx] = (m_pht[tidx] < CTR_MAX) ? m_pht[tidx] + 1 : CTR_MAX;
      else    m_pht[tidx] = (m_pht[tidx] > 0) ? m_pht[tidx] - 1 : 0;
    end
    if (tv && tm)  m_ghr = {th[5:0], tt};
    else if (pv)   m_ghr = {m_ghr[5:0], pt};
    if (pv && m_sp < 65535)        m_sp++;
    if (tv && tm && m_smp < 65535) m_smp++;
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  // Combinational look at predict_taken without issuing a request.
  task automatic peek(input logic [6:0] ppc, output logic taken);
    bus.predict_valid = 1'b0;
    bus.predict_pc    = ppc;
    #2;
    taken = bus.predict_taken;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_sp"},  32'(bus.stat_predicts),    32'(m_sp));
    check({tag, "_smp"}, 32'(bus.stat_mispredicts), 32'(m_smp));
  endtask

  // Absolute time guard.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic       t;
    logic [6:0] g;
    drive_idle();
    model_reset();

    // 1: reset values and sweep length
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy",  32'(bus.init_busy), 32'd1);
    check("rst_state", 32'(bus.state), 32'(ST_INIT));
    check("rst_pt",    32'(bus.predict_taken), 32'd0);
    check("rst_ph",    32'(bus.predict_history), 32'd0);
    check("rst_sp",    32'(bus.stat_predicts), 32'd0);
    check("rst_smp",   32'(bus.stat_mispredicts), 32'd0);
    rst_n = 1'b1;
    model_reset();
    wait_sweep("s1", 128, 1'b0);
    check("s1_state", 32'(bus.state), 32'(ST_RUN));

    // 2: mispredict repair
    do_cycle(1'b1, 7'd10, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0);
    do_cycle(1'b0, 7'd0, 1'b1, 7'd10, 1'b1, 1'b1, 7'd0);
    check("s2_ghr", 32'(bus.predict_history), 32'h01);
    check("s2_smp", 32'(bus.stat_mispredicts), 32'd1);
    peek(7'd11, t);
    check("s2_pt", {31'd0, t}, 32'd1);
    do_cycle(1'b1, 7'd11, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0);
    check_stats("s2");

    // 3: counter saturation at idx 5
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 7'd0, 1'b1, 7'd5, 1'b1, 1'b0, 7'd0);
    do_cycle(1'b0, 7'd0, 1'b1, 7'd5, 1'b0, 1'b0, 7'd0);
    peek(7'd5 ^ m_ghr, t);
    check("s3_sat_hi", {31'd0, t}, 32'd1);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 7'd0, 1'b1, 7'd5, 1'b0, 1'b0, 7'd0);
    do_cycle(1'b0, 7'd0, 1'b1, 7'd5, 1'b1, 1'b0, 7'd0);
    peek(7'd5 ^ m_ghr, t);
    check("s3_sat_lo", {31'd0, t}, 32'd0);
    do_cycle(1'b0, 7'd0, 1'b1, 7'd5, 1'b1, 1'b0, 7'd0);
    do_cycle(1'b1, 7'd5 ^ m_ghr, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0);

    // 4: predict and mispredicted train on the same index
    g = m_ghr;
    do_cycle(1'b1, 7'd20, 1'b1, (7'd20 ^ g) ^ 7'h2A, 1'b1, 1'b1, 7'h2A);
    check("s4_ghr", 32'(bus.predict_history), 32'h55);
    check_stats("s4");
    peek((7'd20 ^ g) ^ 7'h55, t);
    check("s4_upd", {31'd0, t}, 32'd1);
    do_cycle(1'b1, (7'd20 ^ g) ^ 7'h55, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0);

    // 5: requests pulsed during the sweep are ignored
    do_reset();
    wait_sweep("s5", 128, 1'b1);
    check_stats("s5");
    check("s5_ghr", 32'(bus.predict_history), 32'd0);
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 7'(i), 1'b0, 7'd0, 1'b0, 1'b0, 7'd0);
    check("s5_ghr_end", 32'(bus.predict_history), 32'd0);

    // 6: statistic saturation, then reset mid-sweep
    do_reset();
    wait_sweep("s6a", 128, 1'b0);
    for (int i = 0; i < 20; i++)
      do_cycle(1'b1, 7'($urandom_range(0, 127)), 1'b0, 7'd0, 1'b0, 1'b0, 7'd0);
    check_stats("s6");
    check("s6_sp4",  32'(bus4.stat_predicts), 32'd15);
    check("s6_smp4", 32'(bus4.stat_mispredicts), 32'd0);
    do_reset();
    for (int i = 0; i < 50; i++) @(posedge clk);
    #1;
    check("s6_mid_busy", 32'(bus.init_busy), 32'd1);
    do_reset();
    wait_sweep("s6b", 128, 1'b0);
    check("s6_sp4_clr", 32'(bus4.stat_predicts), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
